// File: rtl/ulpi_link_ctrl.sv
// ULPI link-side controller.
// Bridges a byte/packet interface to a ULPI PHY bus. All ULPI pins, including the
// PHY's 60 MHz clock, are sampled as data on the faster system clock. Bus decisions
// are taken only in the single system cycle that follows a rising ulpi_clk ("tick").
//
// Ports
//   clk, rst                   system clock, asynchronous active-high reset
//   ulpi_clk/dir/nxt/data_in   PHY pins, registered once before use
//   ulpi_data_out, ulpi_stp    link-driven bus pins
//   tx_start/payload/len       transmit request (payload byte 0 in the top bits)
//   tx_ready/busy/done/abort   transmit status; done and abort are 1-cycle pulses
//   rx_data/rx_valid           received data byte and its strobe
//   rx_cmd/rx_cmd_valid        received RX CMD byte and its strobe
//   rx_active/eop/err/count    receive packet framing and byte count

module ulpi_link_ctrl #(
    parameter int unsigned MAX_BYTES = 66,
    parameter logic [7:0]  TX_CMD    = 8'h40,
    parameter int unsigned LEN_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ulpi_clk,
    input  logic                   ulpi_dir,
    input  logic                   ulpi_nxt,
    input  logic [7:0]             ulpi_data_in,
    output logic [7:0]             ulpi_data_out,
    output logic                   ulpi_stp,
    input  logic                   tx_start,
    input  logic [MAX_BYTES*8-1:0] tx_payload,
    input  logic [LEN_W-1:0]       tx_len,
    output logic                   tx_ready,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_abort,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic [7:0]             rx_cmd,
    output logic                   rx_cmd_valid,
    output logic                   rx_active,
    output logic                   rx_eop,
    output logic                   rx_err,
    output logic [LEN_W-1:0]       rx_count
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StTxCmd  = 3'd1;
    localparam logic [2:0] StTxData = 3'd2;
    localparam logic [2:0] StTxStop = 3'd3;
    localparam logic [2:0] StTurn   = 3'd4;
    localparam logic [2:0] StRx     = 3'd5;

    logic                   ulpi_clk_q, ulpi_clk_qq, dir_q, nxt_q;
    logic [7:0]             din_q;
    logic                   tick;

    logic [2:0]             state_q, state_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [MAX_BYTES*8-1:0] payload_q, payload_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_abort_q, tx_abort_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [7:0]             rx_cmd_q, rx_cmd_d;
    logic                   rx_cmd_valid_q, rx_cmd_valid_d;
    logic                   rx_active_q, rx_active_d;
    logic                   rx_eop_q, rx_eop_d;
    logic                   rx_err_q, rx_err_d;
    logic [LEN_W-1:0]       rx_count_q, rx_count_d;

    assign tick = ulpi_clk_q & ~ulpi_clk_qq;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        len_d          = len_q;
        payload_d      = payload_q;
        tx_done_d      = 1'b0;
        tx_abort_d     = 1'b0;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_cmd_d       = rx_cmd_q;
        rx_cmd_valid_d = 1'b0;
        rx_active_d    = rx_active_q;
        rx_eop_d       = 1'b0;
        rx_err_d       = 1'b0;
        rx_count_d     = rx_count_q;

        case (state_q)
            StIdle: begin
                // IDLE is only ever entered with dir_q low, so a high level here is
                // a rising edge; it wins over a simultaneous tx_start.
                if (dir_q) begin
                    state_d = StTurn;
                end else if (tx_start) begin
                    if (tx_len == '0) begin
                        tx_done_d = 1'b1;
                    end else begin
                        payload_d = tx_payload;
                        len_d     = (tx_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : tx_len;
                        idx_d     = '0;
                        state_d   = StTxCmd;
                    end
                end
            end
            StTxCmd: begin
                if (dir_q) begin
                    tx_abort_d = 1'b1;
                    state_d    = StTurn;
                end else if (tick && nxt_q) begin
                    idx_d   = '0;
                    state_d = StTxData;
                end
            end
            StTxData: begin
                if (dir_q) begin
                    tx_abort_d = 1'b1;
                    state_d    = StTurn;
                end else if (tick && nxt_q) begin
                    // Payload shifts so the byte on the bus is always the top one.
                    payload_d = payload_q << 8;
                    if ((idx_q + 1'b1) == len_q) begin
                        state_d = StTxStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StTxStop: begin
                if (tick) begin
                    tx_done_d = 1'b1;
                    state_d   = dir_q ? StTurn : StIdle;
                end
            end
            StTurn: begin
                if (!dir_q) begin
                    state_d = StIdle;
                end else if (tick) begin
                    state_d = StRx;
                end
            end
            StRx: begin
                if (!dir_q) begin
                    state_d = StIdle;
                    if (rx_active_q) begin
                        rx_eop_d    = 1'b1;
                        rx_active_d = 1'b0;
                    end
                end else if (tick) begin
                    if (nxt_q) begin
                        rx_data_d  = din_q;
                        rx_valid_d = 1'b1;
                        if (rx_count_q != {LEN_W{1'b1}}) begin
                            rx_count_d = rx_count_q + 1'b1;
                        end
                    end else begin
                        rx_cmd_d       = din_q;
                        rx_cmd_valid_d = 1'b1;
                        if (din_q[5:4] == 2'b01) begin
                            rx_active_d = 1'b1;
                            if (!rx_active_q) begin
                                rx_count_d = '0;
                            end
                        end else if (din_q[5:4] == 2'b11) begin
                            // Error ends the packet without an end-of-packet strobe.
                            rx_err_d    = 1'b1;
                            rx_active_d = 1'b0;
                        end else begin
                            rx_active_d = 1'b0;
                            rx_eop_d    = rx_active_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ulpi_clk_q     <= 1'b0;
            ulpi_clk_qq    <= 1'b0;
            dir_q          <= 1'b0;
            nxt_q          <= 1'b0;
            din_q          <= '0;
            state_q        <= StIdle;
            idx_q          <= '0;
            len_q          <= '0;
            payload_q      <= '0;
            tx_done_q      <= 1'b0;
            tx_abort_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_cmd_q       <= '0;
            rx_cmd_valid_q <= 1'b0;
            rx_active_q    <= 1'b0;
            rx_eop_q       <= 1'b0;
            rx_err_q       <= 1'b0;
            rx_count_q     <= '0;
        end else begin
            ulpi_clk_q     <= ulpi_clk;
            ulpi_clk_qq    <= ulpi_clk_q;
            dir_q          <= ulpi_dir;
            nxt_q          <= ulpi_nxt;
            din_q          <= ulpi_data_in;
            state_q        <= state_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            payload_q      <= payload_d;
            tx_done_q      <= tx_done_d;
            tx_abort_q     <= tx_abort_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_cmd_q       <= rx_cmd_d;
            rx_cmd_valid_q <= rx_cmd_valid_d;
            rx_active_q    <= rx_active_d;
            rx_eop_q       <= rx_eop_d;
            rx_err_q       <= rx_err_d;
            rx_count_q     <= rx_count_d;
        end
    end

    // Bus outputs decode flops only; dir_q gating releases the bus in the very
    // cycle the PHY is seen taking it.
    always_comb begin
        ulpi_data_out = 8'h00;
        if (!dir_q) begin
            if (state_q == StTxCmd) begin
                ulpi_data_out = TX_CMD;
            end else if (state_q == StTxData) begin
                ulpi_data_out = payload_q[MAX_BYTES*8-1 -: 8];
            end
        end
    end

    assign ulpi_stp     = (state_q == StTxStop);
    assign tx_ready     = (state_q == StIdle) && !dir_q;
    assign tx_busy      = (state_q == StTxCmd) || (state_q == StTxData) || (state_q == StTxStop);
    assign tx_done      = tx_done_q;
    assign tx_abort     = tx_abort_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_cmd       = rx_cmd_q;
    assign rx_cmd_valid = rx_cmd_valid_q;
    assign rx_active    = rx_active_q;
    assign rx_eop       = rx_eop_q;
    assign rx_err       = rx_err_q;
    assign rx_count     = rx_count_q;

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Bench for ulpi_link_ctrl: a PHY model toggles ulpi_clk every two system cycles
// and compares the bus and the framing outputs against expectations built from
// the transfer rules (expected byte streams, packet counts, saturating counters).

module tb_ulpi_link_ctrl;
    localparam int         MB  = 66;
    localparam int         LW  = 7;
    localparam logic [7:0] CMD = 8'h40;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ulpi_clk = 1'b0, ulpi_dir = 1'b0, ulpi_nxt = 1'b0;
    logic [7:0]      ulpi_data_in = 8'h00;
    logic [7:0]      ulpi_data_out;
    logic            ulpi_stp;
    logic            tx_start = 1'b0;
    logic [MB*8-1:0] tx_payload = '0;
    logic [LW-1:0]   tx_len = '0;
    logic            tx_ready, tx_busy, tx_done, tx_abort;
    logic [7:0]      rx_data, rx_cmd;
    logic            rx_valid, rx_cmd_valid, rx_active, rx_eop, rx_err;
    logic [LW-1:0]   rx_count;

    ulpi_link_ctrl #(.MAX_BYTES(MB), .TX_CMD(CMD), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .ulpi_clk(ulpi_clk), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
        .ulpi_data_in(ulpi_data_in), .ulpi_data_out(ulpi_data_out), .ulpi_stp(ulpi_stp),
        .tx_start(tx_start), .tx_payload(tx_payload), .tx_len(tx_len), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_abort(tx_abort), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid),
        .rx_active(rx_active), .rx_eop(rx_eop), .rx_err(rx_err), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse monitor: every high cycle counts, so a stretched pulse shows up as extra.
    int         c_done = 0, c_abort = 0, c_eop = 0, c_err = 0;
    logic [7:0] got_data[$];
    logic [7:0] got_cmd[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_done)      c_done++;
            if (tx_abort)     c_abort++;
            if (rx_eop)       c_eop++;
            if (rx_err)       c_err++;
            if (rx_valid)     got_data.push_back(rx_data);
            if (rx_cmd_valid) got_cmd.push_back(rx_cmd);
        end
    end

    // Model state carried across scenarios: received-byte count of the current packet.
    int   m_count = 0;
    logic ev_nxt[$];
    logic [7:0] ev_dat[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One PHY clock period; called at a negedge, returns at a negedge. The bus is
    // sampled in the tick cycle (first system cycle after ulpi_clk rises).
    task automatic ulpi_cycle(input logic nxt, input logic [7:0] din,
                              output logic [7:0] dout, output logic stp_s);
        ulpi_clk = 1'b1;
        ulpi_nxt = nxt;
        ulpi_data_in = din;
        @(negedge clk);
        dout  = ulpi_data_out;
        stp_s = ulpi_stp;
        @(negedge clk);
        ulpi_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] rcmd(input logic [1:0] a);
        logic [7:0] c;
        c = 8'($urandom);
        c[5:4] = a;
        return c;
    endfunction

    task automatic test_reset;
        n_cmp++;
        if ({ulpi_data_out, ulpi_stp, tx_ready, tx_busy, tx_done, tx_abort} !== {8'h00, 5'b01000}) begin
            n_bad++;
            $display("FAIL reset_tx: got %h/%b%b%b%b%b want 00/01000", ulpi_data_out, ulpi_stp,
                     tx_ready, tx_busy, tx_done, tx_abort);
        end
        n_cmp++;
        if ({rx_data, rx_valid, rx_cmd, rx_cmd_valid, rx_active, rx_eop, rx_err, rx_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_rx: got %h %b %h %b %b %b %b %0d want all zero", rx_data, rx_valid,
                     rx_cmd, rx_cmd_valid, rx_active, rx_eop, rx_err, rx_count);
        end
    endtask

    task automatic run_tx(input string name, input int len, input bit seq_bytes, input bit rnd_nxt,
                          input int stall_at);
        logic [7:0] exp_q[$];
        logic [7:0] b, d;
        logic       s, nxt;
        int         n, pos, guard, done0;
        bit         stalled;
        n = (len > MB) ? MB : len;
        tx_payload = '0;
        exp_q.push_back(CMD);
        for (int i = 0; i < n; i++) begin
            b = seq_bytes ? 8'(i) : 8'($urandom);
            tx_payload[(MB-1-i)*8 +: 8] = b;
            exp_q.push_back(b);
        end
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready: got %b want 1", name, tx_ready);
        end
        done0 = c_done;
        tx_len = LW'(len);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n_cmp++;
        if (tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy: got %b want 1", name, tx_busy);
        end
        pos = 0;
        guard = 0;
        stalled = 0;
        while (pos < n + 1 && guard < 600) begin
            if (rnd_nxt) nxt = ($urandom_range(3) != 0);
            else if (pos == stall_at + 1 && !stalled) begin
                nxt = 1'b0;
                stalled = 1;
            end else nxt = 1'b1;
            ulpi_cycle(nxt, 8'($urandom), d, s);
            n_cmp++;
            if (d !== exp_q[pos] || s !== 1'b0) begin
                n_bad++;
                $display("FAIL %s bus[%0d]: got %h stp %b want %h stp 0", name, pos, d, s, exp_q[pos]);
            end
            if (nxt) pos++;
            guard++;
        end
        if (guard >= 600) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got pos %0d want %0d", name, pos, n + 1);
        end
        ulpi_cycle(1'b0, 8'h00, d, s);
        n_cmp++;
        if (s !== 1'b1 || d !== 8'h00) begin
            n_bad++;
            $display("FAIL %s stop: got stp %b data %h want stp 1 data 00", name, s, d);
        end
        ulpi_cycle(1'b0, 8'h00, d, s);
        n_cmp++;
        if (s !== 1'b0) begin
            n_bad++;
            $display("FAIL %s stp_len: got stp %b on second tick want 0", name, s);
        end
        n_cmp++;
        if (c_done - done0 !== 1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done: got %0d pulses busy %b ready %b want 1 0 1", name,
                     c_done - done0, tx_busy, tx_ready);
        end
    endtask

    task automatic test_len_zero;
        int done0;
        done0 = c_done;
        tx_len = '0;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n_cmp++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || ulpi_stp !== 1'b0 || ulpi_data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL len0: got done %b busy %b stp %b data %h want 1 0 0 00", tx_done, tx_busy,
                     ulpi_stp, ulpi_data_out);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (c_done - done0 !== 1 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL len0_pulse: got %0d pulses ready %b want 1 1", c_done - done0, tx_ready);
        end
    endtask

    task automatic test_abort;
        logic [7:0] b[20];
        logic [7:0] d;
        logic       s;
        int         a0, d0, c0;
        tx_payload = '0;
        for (int i = 0; i < 20; i++) begin
            b[i] = 8'($urandom_range(1, 255));
            tx_payload[(MB-1-i)*8 +: 8] = b[i];
        end
        a0 = c_abort;
        d0 = c_done;
        tx_len = LW'(20);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        ulpi_cycle(1'b1, 8'h00, d, s);
        for (int i = 0; i < 10; i++) ulpi_cycle(1'b1, 8'h00, d, s);
        n_cmp++;
        if (ulpi_data_out !== b[10]) begin
            n_bad++;
            $display("FAIL abort_pre: got %h want %h", ulpi_data_out, b[10]);
        end
        ulpi_dir = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ulpi_data_out !== 8'h00 || ulpi_stp !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_bus: got data %h stp %b want 00 0", ulpi_data_out, ulpi_stp);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (tx_busy !== 1'b0 || ulpi_stp !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_busy: got busy %b stp %b want 0 0", tx_busy, ulpi_stp);
        end
        c0 = got_cmd.size();
        ulpi_cycle(1'b0, 8'h10, d, s);
        n_cmp++;
        if (got_cmd.size() !== c0) begin
            n_bad++;
            $display("FAIL abort_turn: got %0d rx_cmd strobes want 0", got_cmd.size() - c0);
        end
        ulpi_cycle(1'b0, 8'h2C, d, s);
        n_cmp++;
        if (got_cmd.size() !== c0 + 1 || got_cmd[got_cmd.size()-1] !== 8'h2C) begin
            n_bad++;
            $display("FAIL abort_rx: got %0d strobes want 1 of 2c", got_cmd.size() - c0);
        end
        n_cmp++;
        if (c_abort - a0 !== 1 || c_done - d0 !== 0 || rx_active !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pulse: got abort %0d done %0d active %b want 1 0 0",
                     c_abort - a0, c_done - d0, rx_active);
        end
        ulpi_dir = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready: got %b want 1", tx_ready);
        end
    endtask

    // Plays the queued RX events through a full dir high period and checks framing.
    task automatic run_rx(input string name);
        logic [7:0] ed[$];
        logic [7:0] ec[$];
        logic [7:0] d, c;
        logic       s;
        bit         act;
        int         nd0, nc0, e0, r0, ee, er;
        nd0 = got_data.size();
        nc0 = got_cmd.size();
        e0 = c_eop;
        r0 = c_err;
        ee = 0;
        er = 0;
        act = 0;
        ulpi_dir = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ulpi_cycle(1'b0, 8'h10, d, s);
        n_cmp++;
        if (got_cmd.size() !== nc0) begin
            n_bad++;
            $display("FAIL %s turn: got %0d rx_cmd strobes want 0", name, got_cmd.size() - nc0);
        end
        for (int i = 0; i < ev_nxt.size(); i++) begin
            ulpi_cycle(ev_nxt[i], ev_dat[i], d, s);
            c = ev_dat[i];
            if (ev_nxt[i]) begin
                ed.push_back(c);
                if (m_count < 127) m_count++;
            end else begin
                ec.push_back(c);
                if (c[5:4] == 2'b01) begin
                    if (!act) m_count = 0;
                    act = 1;
                end else if (c[5:4] == 2'b11) begin
                    er++;
                    act = 0;
                end else begin
                    if (act) ee++;
                    act = 0;
                end
                n_cmp++;
                if (rx_active !== act) begin
                    n_bad++;
                    $display("FAIL %s active[%0d]: got %b want %b", name, i, rx_active, act);
                end
            end
        end
        n_cmp++;
        if (d !== 8'h00 || s !== 1'b0) begin
            n_bad++;
            $display("FAIL %s rx_bus: got data %h stp %b want 00 0", name, d, s);
        end
        ulpi_dir = 1'b0;
        repeat (3) @(negedge clk);
        if (act) ee++;
        n_cmp++;
        if (got_data.size() - nd0 !== ed.size()) begin
            n_bad++;
            $display("FAIL %s ndata: got %0d want %0d", name, got_data.size() - nd0, ed.size());
        end else begin
            for (int i = 0; i < ed.size(); i++) begin
                n_cmp++;
                if (got_data[nd0+i] !== ed[i]) begin
                    n_bad++;
                    $display("FAIL %s data[%0d]: got %h want %h", name, i, got_data[nd0+i], ed[i]);
                end
            end
        end
        n_cmp++;
        if (got_cmd.size() - nc0 !== ec.size()) begin
            n_bad++;
            $display("FAIL %s ncmd: got %0d want %0d", name, got_cmd.size() - nc0, ec.size());
        end else begin
            for (int i = 0; i < ec.size(); i++) begin
                n_cmp++;
                if (got_cmd[nc0+i] !== ec[i]) begin
                    n_bad++;
                    $display("FAIL %s cmd[%0d]: got %h want %h", name, i, got_cmd[nc0+i], ec[i]);
                end
            end
        end
        n_cmp++;
        if (c_eop - e0 !== ee || c_err - r0 !== er) begin
            n_bad++;
            $display("FAIL %s framing: got eop %0d err %0d want %0d %0d", name, c_eop - e0,
                     c_err - r0, ee, er);
        end
        n_cmp++;
        if (rx_active !== 1'b0 || int'(rx_count) !== m_count || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s end: got active %b count %0d ready %b want 0 %0d 1", name, rx_active,
                     rx_count, tx_ready, m_count);
        end
        ev_nxt.delete();
        ev_dat.delete();
    endtask

    task automatic add_ev(input logic nxt, input logic [7:0] d);
        ev_nxt.push_back(nxt);
        ev_dat.push_back(d);
    endtask

    task automatic test_rx_basic;
        add_ev(1'b0, 8'h10);
        add_ev(1'b1, 8'hA5);
        add_ev(1'b1, 8'h5A);
        add_ev(1'b1, 8'hC3);
        add_ev(1'b0, 8'h00);
        run_rx("rx_basic");
    endtask

    task automatic test_rx_err;
        add_ev(1'b0, 8'h10);
        add_ev(1'b1, 8'h11);
        add_ev(1'b1, 8'h22);
        add_ev(1'b0, 8'h30);
        run_rx("rx_err");
    endtask

    task automatic test_rx_random;
        for (int sess = 0; sess < 3; sess++) begin
            for (int p = 0; p < 3; p++) begin
                add_ev(1'b0, rcmd(2'b01));
                for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                    if ($urandom_range(4) == 0) add_ev(1'b0, rcmd(2'b01));
                    add_ev(1'b1, 8'($urandom));
                end
                case ($urandom_range(3))
                    0: add_ev(1'b0, rcmd(2'b00));
                    1: add_ev(1'b0, rcmd(2'b10));
                    2: add_ev(1'b0, rcmd(2'b11));
                    default: ;
                endcase
            end
            run_rx("rx_rand");
        end
    endtask

    task automatic test_rx_saturate;
        add_ev(1'b0, 8'h10);
        for (int i = 0; i < 130; i++) add_ev(1'b1, 8'($urandom));
        add_ev(1'b0, 8'h00);
        run_rx("rx_sat");
    endtask

    task automatic test_reset_mid_tx;
        logic [7:0] b[30];
        logic [7:0] d;
        logic       s;
        tx_payload = '0;
        for (int i = 0; i < 30; i++) begin
            b[i] = 8'($urandom_range(1, 255));
            tx_payload[(MB-1-i)*8 +: 8] = b[i];
        end
        tx_len = LW'(30);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < 5; i++) ulpi_cycle(1'b1, 8'h00, d, s);
        n_cmp++;
        if (ulpi_data_out !== b[4] || tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: got %h busy %b want %h 1", ulpi_data_out, tx_busy, b[4]);
        end
        rst = 1'b1;
        ulpi_clk = 1'b0;
        #1;
        n_cmp++;
        if (ulpi_stp !== 1'b0 || ulpi_data_out !== 8'h00 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: got stp %b data %h busy %b want 0 00 0", ulpi_stp,
                     ulpi_data_out, tx_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        m_count = 0;
        @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1 || rx_count !== '0) begin
            n_bad++;
            $display("FAIL rst_release: got ready %b count %0d want 1 0", tx_ready, rx_count);
        end
        run_tx("tx_after_rst", 8, 1'b0, 1'b0, -1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        run_tx("tx_full", 66, 1'b1, 1'b0, -1);
        run_tx("tx_stall", 3, 1'b0, 1'b0, 1);
        test_len_zero;
        run_tx("tx_clamp", 127, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) run_tx("tx_rand", int'($urandom_range(1, MB)), 1'b0, 1'b1, -1);
        test_abort;
        test_rx_basic;
        test_rx_err;
        test_rx_random;
        test_rx_saturate;
        run_tx("tx_after_rx", 5, 1'b0, 1'b1, -1);
        test_reset_mid_tx;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ulpi_link_ctrl.md
Name: ulpi_link_ctrl

Overview:
- Parametrised ULPI link-side controller. Bridges the internal byte/packet interface to a ULPI PHY bus.
- Transmit: sends a TX CMD byte followed by a variable-length payload, obeying PHY nxt throttling and dir-driven aborts.
- Receive: decodes RX CMD bytes and data bytes into a byte stream with packet framing and error flags.
- Sits between the packet assembler/parser logic and the ULPI pins, all on the system clock.

Parameters:
- MAX_BYTES, 66, payload buffer capacity in bytes (16*4+2).
- TX_CMD, 8'h40, byte driven during the TX CMD phase.
- LEN_W, 7, width of tx_len and rx_count; must satisfy 2^LEN_W > MAX_BYTES.

Ports:
- clk, input, 1, system clock; oversamples the ULPI bus.
- rst, input, 1, reset: asynchronous, active-high.
- ulpi_clk, input, 1, 60 MHz PHY clock, sampled as data.
- ulpi_dir, input, 1, PHY bus direction (1 = PHY drives).
- ulpi_nxt, input, 1, PHY throttle/data strobe.
- ulpi_data_in, input, 8, bus data from the PHY.
- ulpi_data_out, output, 8, bus data to the PHY.
- ulpi_stp, output, 1, stop strobe.
- tx_start, input, 1, start request; accepted only when tx_ready=1.
- tx_payload, input, MAX_BYTES*8, payload; byte 0 = bits [MAX_BYTES*8-1 -: 8].
- tx_len, input, LEN_W, number of bytes to send.
- tx_ready, output, 1, controller can accept tx_start.
- tx_busy, output, 1, transmit in progress.
- tx_done, output, 1, 1-cycle pulse on normal completion.
- tx_abort, output, 1, 1-cycle pulse when the PHY seized the bus mid-transmit.
- rx_data, output, 8, last received data byte.
- rx_valid, output, 1, 1-cycle pulse when rx_data is updated.
- rx_cmd, output, 8, last RX CMD byte.
- rx_cmd_valid, output, 1, 1-cycle pulse when rx_cmd is updated.
- rx_active, output, 1, level; RxActive decoded from rx_cmd[5:4]==01.
- rx_eop, output, 1, 1-cycle pulse at end of a received packet.
- rx_err, output, 1, 1-cycle pulse when an RX CMD has [5:4]==11.
- rx_count, output, LEN_W, data bytes received in the current packet; saturates at all-ones.

Behaviour:

Input sampling:
- ulpi_clk, ulpi_dir, ulpi_nxt and ulpi_data_in are each registered once (_q).
- ulpi_clk is registered a second time (_qq).
- tick = ulpi_clk_q & ~ulpi_clk_qq. All bus decisions use _q values in the tick cycle.

Reset:
- State returns to IDLE. All outputs are 0, except tx_ready, which is 1 when ulpi_dir_q=0.
- Payload register and counters are cleared.
- Reset mid-transfer drops stp and data_out to 0 immediately.

States:
- IDLE:
  - tx_ready = ~ulpi_dir_q.
  - A rising edge of ulpi_dir_q goes to TURN; this has priority over tx_start in the same cycle.
  - tx_start with tx_len==0 pulses tx_done next cycle with no bus activity.
  - tx_start with tx_len > MAX_BYTES is clamped to MAX_BYTES.
  - Otherwise latch the payload and length, set tx_busy, and go to TX_CMD.
- TX_CMD:
  - data_out = TX_CMD.
  - On a tick with nxt_q=1: go to TX_DATA at byte index 0.
- TX_DATA:
  - data_out = payload byte[index].
  - On a tick with nxt_q=1: index increments.
  - On acceptance of the byte at index tx_len-1: go to TX_STOP.
  - A tick with nxt_q=0 holds the current byte (stall).
- TX_STOP:
  - data_out = 0, stp = 1.
  - On the next tick: stp=0, tx_busy=0, tx_done pulses, go to IDLE.
- Abort:
  - ulpi_dir_q=1 in any cycle of TX_CMD or TX_DATA forces data_out=0 and stp=0 that cycle.
  - tx_abort pulses, tx_busy clears, and the state goes to TURN.
  - No tx_done is issued for an aborted transmit.
  - dir rising during TX_STOP: stp completes, then the state goes to TURN instead of IDLE, and tx_done still pulses.
- TURN:
  - Turnaround; data is ignored; data_out = 0.
  - On the next tick: go to RX.
- RX:
  - tick with nxt_q=1: rx_data=data_in_q; rx_valid pulses; rx_count increments.
  - tick with nxt_q=0: rx_cmd=data_in_q; rx_cmd_valid pulses; rx_active = (data_in_q[5:4]==01).
  - rx_active 0→1 clears rx_count.
  - rx_active 1→0 pulses rx_eop.
  - data_in_q[5:4]==11 pulses rx_err and clears rx_active without an rx_eop.
- Direction drop:
  - ulpi_dir_q=0 in RX or TURN (any cycle, tick not required) goes to IDLE.
  - If rx_active was 1: rx_eop pulses and rx_active clears.
  - rx_count holds until the next packet.

General output rules:
- All outputs are registered.
- Pulses are exactly one clk cycle.
- data_out is 0 whenever the state is not TX_CMD or TX_DATA.

Test Plan:
- nxt held 1, tx_len=66, payload bytes 0x00..0x41 → bus shows 0x40 then 0x00..0x41 on successive ticks; stp high for one tick; tx_done pulses once.
- tx_len=3, nxt low on the tick of byte 1 → byte 1 is held for two ticks; the total bus sequence is 0x40,b0,b1,b1,b2; then stp.
- dir raised while byte 10 is driven → data_out=0 the same cycle; tx_abort pulses; no stp and no tx_done; next tick enters RX.
- PHY sends RX CMD 0x10, data A5,5A,C3 with nxt=1, RX CMD 0x00, dir low → rx_active rises; three rx_valid pulses with matching bytes; rx_count=3; one rx_eop.
- RX CMD 0x30 mid-packet → rx_err pulses; rx_active drops; no rx_eop. Then dir falls → no extra rx_eop.
- rst asserted while in TX_DATA → stp, data_out and tx_busy are 0 in the same cycle; tx_ready=1 after release; a new tx_start sends from byte 0.
